i2s_tx_multi: RTL and testbench

I2S_TX_MULTI -- requirements
Module: i2s_tx_multi

---
 rtl/i2s_tx_multi.sv | 187 ++++++++++++++++++
 tb/tb_i2s_tx_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_multi.sv
// rtl/i2s_tx_multi.sv - multi-channel I2S/TDM serial transmitter fed by a frame FIFO
// Build option I2S_TX_UNDERRUN_HOLD_EN: an underrun resends the last popped frame instead of zeros.
module i2s_tx_multi #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int CHANNELS   = 2,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         iCLK_50,
    input  logic                         iRESET_n,
    input  logic                         iENABLE,
    input  logic                         iTDM,
    input  logic [CHANNELS*SAMPLE_W-1:0] iSAMPLE,
    input  logic                         iVALID,
    output logic                         oREADY,
    output logic                         oBCLK,
    output logic                         oLRCK,
    output logic                         oSDATA,
    output logic [$clog2(FIFO_DEPTH):0]  oLEVEL,
    output logic                         oUNDERRUN
);
    localparam int FW    = CHANNELS * SAMPLE_W;
    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = $clog2(FRAME);
    localparam int CW    = $clog2(BCLK_DIV);
    localparam int IW    = $clog2(FW);
    localparam logic [AW:0]    DEPTH_L  = FIFO_DEPTH[AW:0];
    localparam logic [CW-1:0]  CYC_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0]  CYC_HALF = CW'(BCLK_DIV / 2);
    localparam logic [BW-1:0]  BIT_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0]  BIT_HALF = BW'(FRAME / 2);
    localparam bit             LAST_IN  = (SLOT_W == SAMPLE_W);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

    // Assertion is immediate through the flops' async clear; release takes two clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q;
    logic          full, empty, push, pop;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);
    assign push  = iVALID && (!full || pop);

    always_ff @(posedge iCLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (push) mem_q[wr_q] <= iSAMPLE;
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          prev_q, prev_d, tdm_q, tdm_d, drain_q, drain_d, undr_q, undr_d;

    always_ff @(posedge iCLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            prev_q  <= 1'b0;
            tdm_q   <= 1'b0;
            drain_q <= 1'b0;
            undr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            prev_q  <= prev_d;
            tdm_q   <= tdm_d;
            drain_q <= drain_d;
            undr_q  <= undr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        prev_d  = prev_q;
        tdm_d   = tdm_q;
        drain_d = drain_q;
        undr_d  = undr_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (iENABLE && !empty) begin
                    pop     = 1'b1;
                    frame_d = mem_q[rd_q];
                    tdm_d   = iTDM;
                    undr_d  = 1'b0;
                    prev_d  = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                    drain_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (drain_q) begin
                        state_d = STOP;
                    end else if (bit_q == BIT_LAST) begin
                        // Bit 0 of the next frame carries the last slot's final bit.
                        bit_d  = '0;
                        prev_d = LAST_IN ? frame_q[(CHANNELS-1)*SAMPLE_W] : 1'b0;
                        if (!iENABLE) begin
                            drain_d = 1'b1;
                        end else if (!empty) begin
                            pop     = 1'b1;
                            frame_d = mem_q[rd_q];
                        end else begin
                            undr_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                            frame_d = frame_q;
`else
                            frame_d = '0;
`endif
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            STOP: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
                drain_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    logic          sdata;
    int            pos, slot, jpos;
    always_comb begin
        sdata = 1'b0;
        pos   = 0;
        slot  = 0;
        jpos  = 0;
        if (state_q == RUN) begin
            if (bit_q == '0) begin
                sdata = prev_q;
            end else begin
                pos  = int'(bit_q) - 1;
                slot = pos / SLOT_W;
                jpos = pos % SLOT_W;
                if (jpos < SAMPLE_W) sdata = frame_q[IW'(slot*SAMPLE_W + SAMPLE_W - 1 - jpos)];
            end
        end
    end

    assign oBCLK     = (state_q == RUN) && (cyc_q >= CYC_HALF);
    assign oLRCK     = (state_q == RUN) && (tdm_q ? (bit_q == '0) : (bit_q >= BIT_HALF));
    assign oSDATA    = sdata;
    assign oREADY    = !full;
    assign oLEVEL    = level_q;
    assign oUNDERRUN = undr_q;
endmodule

// File: tb/tb_i2s_tx_multi.sv
// tb/tb_i2s_tx_multi.sv - randomized bench with frame-level reference model for i2s_tx_multi
module tb_i2s_tx_multi;
    localparam int SW = 16, SL = 16, CH = 2, DIV = 4, DEP = 4;
    localparam int FRAME = CH * SL, FW = CH * SW, FDIV = FRAME * DIV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, en, tdm, valid;
    logic [FW-1:0] sample;
    logic          ready, bclk, lrck, sdata, und;
    logic [2:0]    level;

    logic          en4, valid4;
    logic [63:0]   sample4;
    logic          ready4, bclk4, lrck4, sdata4, und4;
    logic [2:0]    level4;

    i2s_tx_multi #(.SAMPLE_W(SW), .SLOT_W(SL), .CHANNELS(CH), .BCLK_DIV(DIV), .FIFO_DEPTH(DEP)) dut (
        .iCLK_50(clk), .iRESET_n(rstn), .iENABLE(en), .iTDM(tdm), .iSAMPLE(sample),
        .iVALID(valid), .oREADY(ready), .oBCLK(bclk), .oLRCK(lrck), .oSDATA(sdata),
        .oLEVEL(level), .oUNDERRUN(und));

    i2s_tx_multi #(.SAMPLE_W(16), .SLOT_W(32), .CHANNELS(4), .BCLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
        .iCLK_50(clk), .iRESET_n(rstn), .iENABLE(en4), .iTDM(1'b1), .iSAMPLE(sample4),
        .iVALID(valid4), .oREADY(ready4), .oBCLK(bclk4), .oLRCK(lrck4), .oSDATA(sdata4),
        .oLEVEL(level4), .oUNDERRUN(und4));

    int total = 0, bad = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: FIFO as a queue, serial stream built by placing each sample bit
    // at its frame position, time measured in clocks since the run started.
    logic [FW-1:0]    sb[$];
    int               m_state = 0, t = 0, end_t = 0, rs = 0;
    bit               m_drain = 0, m_tdm = 0, m_und = 0;
    logic [FW-1:0]    m_cur = '0;
    logic [FRAME-1:0] m_stream = '0;
    logic             m_wrap = 1'b0;

    function automatic logic [FRAME-1:0] stream_of(input logic [FW-1:0] f);
        logic [FRAME-1:0] s;
        s = '0;
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < SL; j++)
                s[(c*SL + j + 1) % FRAME] = (j < SW) ? f[c*SW + SW - 1 - j] : 1'b0;
        return s;
    endfunction

    task automatic load_frame(input logic [FW-1:0] f, input logic carry);
        m_cur       = f;
        m_stream    = stream_of(f);
        m_wrap      = m_stream[0];
        m_stream[0] = carry;
    endtask

    always @(posedge clk) begin
        logic [FW-1:0] nf;
        if (!rstn) begin
            sb.delete();
            m_state = 0; m_und = 0; rs = 0; t = 0; m_drain = 0;
        end else if (rs < 2) begin
            rs++;
        end else begin
            case (m_state)
                0: if (en && sb.size() > 0) begin
                    nf = sb.pop_front();
                    load_frame(nf, 1'b0);
                    m_tdm = tdm; m_und = 0; t = 0; m_drain = 0; m_state = 1;
                end
                1: begin
                    t++;
                    if (m_drain && t == end_t) m_state = 2;
                    else if (t % FDIV == 0) begin
                        if (!en) begin
                            m_drain = 1; end_t = t + DIV; m_stream[0] = m_wrap;
                        end else if (sb.size() > 0) begin
                            nf = sb.pop_front();
                            load_frame(nf, m_wrap);
                        end else begin
                            m_und = 1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                            load_frame(m_cur, m_wrap);
`else
                            load_frame('0, m_wrap);
`endif
                        end
                    end
                end
                default: m_state = 0;
            endcase
            if (valid && sb.size() < DEP) sb.push_back(sample);
        end
    end

    always @(negedge clk) begin
        logic eb, el, es;
        logic [2:0] elev;
        int b;
        eb = 0; el = 0; es = 0; b = 0;
        elev = 3'(sb.size());
        if (m_state == 1) begin
            b  = (t / DIV) % FRAME;
            eb = (t % DIV) >= DIV / 2;
            el = m_tdm ? (b == 0) : (b >= FRAME / 2);
            es = m_stream[b];
        end
        if (chk_on)
            chk("cycle_outputs", {bclk, lrck, sdata, ready, und, level},
                {eb, el, es, elev < 3'(DEP), m_und, elev});
    end

    logic        bits [65];
    logic [31:0] lrv;
    logic [3:0]  bcv;
    logic [15:0] w [4];
    logic [15:0] exp_w2, exp_w3;
    int          rate, cnt;
    logic        lr0, b1, b64, b65, b66;

    initial begin
        rstn = 0; en = 0; tdm = 0; valid = 0; sample = '0;
        en4 = 0; valid4 = 0; sample4 = '0;
        repeat (5) @(negedge clk);
        chk_on = 1;
        chk("reset_outputs", {bclk, lrck, sdata, ready, und, level}, 8'b000_1_0_000);
        rstn = 1;
        repeat (4) @(negedge clk);

        // Single frame, run through its underrun, then drop enable mid-frame.
        sample = 32'hBEEF_1234; valid = 1;
        @(negedge clk);
        valid = 0; en = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k % 4 == 2 && k / 4 < 65) bits[k/4] = sdata;
            if (k % 4 == 2 && k / 4 < 32) lrv[k/4] = lrck;
            if (k < 4) bcv[k] = bclk;
            if (k == 127) chk("und_frame0", und, 0);
            if (k == 129) chk("und_frame1", und, 1);
            if (k == 296) en = 0;
            if (k == 336) begin sample = $urandom; valid = 1; end
            if (k == 337) valid = 0;
            if (k == 386) chk("drain_extra_bit_bclk", bclk, 1);
            if (k == 388) chk("stop_outputs", {bclk, lrck, sdata}, 0);
            if (k == 395) chk("no_pop_after_stop", level, 1);
        end
        for (int i = 0; i < 4; i++) begin
            w[i] = '0;
            for (int n = 0; n < 16; n++) w[i] = {w[i][14:0], bits[1 + 16*i + n]};
        end
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        exp_w2 = 16'h1234; exp_w3 = 16'hBEEF;
`else
        exp_w2 = 16'h0000; exp_w3 = 16'h0000;
`endif
        chk("frame0_ch0", w[0], 16'h1234);
        chk("frame0_ch1", w[1], 16'hBEEF);
        chk("underrun_ch0", w[2], exp_w2);
        chk("underrun_ch1", w[3], exp_w3);
        chk("bit0_carry", bits[32], 1);
        chk("lrck_i2s", lrv, 32'hFFFF_0000);
        chk("bclk_shape", bcv, 4'b1100);

        // Reset pulsed mid-frame with one frame queued.
        en = 1;
        repeat (30) @(negedge clk);
        sample = $urandom; valid = 1;
        @(negedge clk);
        valid = 0;
        repeat (30) @(negedge clk);
        #1 rstn = 0;
        #1 chk("async_reset", {bclk, lrck, sdata, ready, und, level}, 8'b000_1_0_000);
        repeat (3) @(negedge clk);
        rstn = 1; en = 0;
        repeat (4) @(negedge clk);

        // Five back-to-back writes into a depth-4 FIFO.
        valid = 1;
        for (int i = 0; i < 5; i++) begin
            sample = $urandom;
            @(negedge clk);
            if (i == 2) chk("ready_after_3", ready, 1);
            if (i == 3) chk("ready_after_4", ready, 0);
        end
        valid = 0;
        chk("level_full", level, 4);
        en = 1; tdm = $urandom % 2;
        repeat (700) @(negedge clk);
        en = 0;
        repeat (300) @(negedge clk);

        // Randomized traffic, enable toggling, alternating write rates.
        rate = 500;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            valid  = ($urandom % 1000) < rate;
            sample = $urandom;
            tdm    = $urandom % 2;
            if ($urandom % 250 == 0) begin
                en   = !en;
                rate = ($urandom % 2) ? 3 : 600;
            end
        end
        valid = 0; en = 0;
        repeat (300) @(negedge clk);

        // Four-channel TDM instance with 32-BCLK slots.
        sample4 = {16'hFFFF, 16'hA5A5, 16'hFFFF, 16'hFFFF}; valid4 = 1;
        @(negedge clk);
        valid4 = 0; en4 = 1;
        cnt = 0; lr0 = 0; b1 = 0; b64 = 1; b65 = 0; b66 = 1;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            if (k % 4 == 2) begin
                cnt += int'(lrck4);
                if (k / 4 == 0)  lr0 = lrck4;
                if (k / 4 == 1)  b1  = sdata4;
                if (k / 4 == 64) b64 = sdata4;
                if (k / 4 == 65) b65 = sdata4;
                if (k / 4 == 66) b66 = sdata4;
            end
        end
        en4 = 0;
        chk("tdm_sync_count", cnt, 1);
        chk("tdm_sync_bit0", lr0, 1);
        chk("tdm_slot0_msb", b1, 1);
        chk("tdm_slot1_pad", b64, 0);
        chk("tdm_slot2_msb", b65, 1);
        chk("tdm_slot2_bit14", b66, 0);
        repeat (600) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
